// File: rtl/counter_step_sequencer.sv
// ============================================================================
//  Module   : counter_step_sequencer
//  Brief    : Command-driven sequencer producing the 4-bit control word
//             {hold, odd, even, up} for a 3-bit step counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_step_sequencer #(
    parameter int STEPS_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_up_i,
    input  logic               cmd_stride2_i,
    input  logic [STEPS_W-1:0] cmd_steps_i,
    input  logic               abort_i,
    output logic [3:0]         ctrl_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               aborted_o,
    output logic [STEPS_W-1:0] steps_left_o
);

    localparam logic [3:0] C_HOLD = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               pend_valid_q, pend_valid_d;
    logic               pend_up_q, pend_up_d;
    logic               pend_s2_q, pend_s2_d;
    logic [STEPS_W-1:0] pend_steps_q, pend_steps_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               start;
    logic               start_up;
    logic               start_s2;
    logic [STEPS_W-1:0] start_steps;

    assign cmd_ready_o = !pend_valid_q && !abort_i;
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_up_d    = pend_up_q;
        pend_s2_d    = pend_s2_q;
        pend_steps_d = pend_steps_q;
        steps_left_d = steps_left_q;
        ctrl_d       = C_HOLD;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        start        = 1'b0;
        start_up     = cmd_up_i;
        start_s2     = cmd_stride2_i;
        start_steps  = cmd_steps_i;

        case (state_q)
            S_IDLE: start = accept;
            S_RUN: begin
                ctrl_d = ctrl_q;
                // Guarded with <= so a corrupted zero count still terminates
                if (steps_left_q <= STEPS_W'(1)) begin
                    state_d      = S_FIN;
                    ctrl_d       = C_HOLD;
                    steps_left_d = '0;
                    done_d       = 1'b1;
                end else begin
                    steps_left_d = steps_left_q - STEPS_W'(1);
                end
                if (accept) begin
                    pend_valid_d = 1'b1;
                    pend_up_d    = cmd_up_i;
                    pend_s2_d    = cmd_stride2_i;
                    pend_steps_d = cmd_steps_i;
                end
            end
            S_FIN: begin
                if (pend_valid_q) begin
                    start        = 1'b1;
                    start_up     = pend_up_q;
                    start_s2     = pend_s2_q;
                    start_steps  = pend_steps_q;
                    pend_valid_d = 1'b0;
                end else if (accept) begin
                    start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A zero-step command skips RUN and completes straight away
        if (start) begin
            if (start_steps != '0) begin
                state_d      = S_RUN;
                ctrl_d       = {1'b0, start_s2, start_s2, start_up};
                steps_left_d = start_steps;
            end else begin
                state_d      = S_FIN;
                ctrl_d       = C_HOLD;
                steps_left_d = '0;
                done_d       = 1'b1;
            end
        end

        if (abort_i) begin
            state_d      = S_IDLE;
            pend_valid_d = 1'b0;
            ctrl_d       = C_HOLD;
            steps_left_d = '0;
            done_d       = 1'b0;
            aborted_d    = 1'b1;
        end

        busy_d = (state_d != S_IDLE) || pend_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            pend_up_q    <= 1'b0;
            pend_s2_q    <= 1'b0;
            pend_steps_q <= '0;
            steps_left_q <= '0;
            ctrl_q       <= C_HOLD;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_up_q    <= pend_up_d;
            pend_s2_q    <= pend_s2_d;
            pend_steps_q <= pend_steps_d;
            steps_left_q <= steps_left_d;
            ctrl_q       <= ctrl_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            busy_q       <= busy_d;
        end
    end

    assign ctrl_o       = ctrl_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign steps_left_o = steps_left_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_step_sequencer.sv
// ============================================================================
//  Module   : tb_counter_step_sequencer
//  Brief    : Vector-table and directed-sequence bench for the step sequencer,
//             with a behavioural 3-bit counter driven by the control word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_step_sequencer;

    localparam int C_STEPS_W = 8;

    logic                 clk = 1'b0;
    logic                 r_reset;
    logic                 r_valid;
    logic                 r_up;
    logic                 r_s2;
    logic [C_STEPS_W-1:0] r_steps;
    logic                 r_abort;
    logic                 w_ready;
    logic [3:0]           w_ctrl;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_aborted;
    logic [C_STEPS_W-1:0] w_steps_left;
    logic [2:0]           r_cnt;

    int errors = 0;
    int checks = 0;

    counter_step_sequencer #(.STEPS_W(C_STEPS_W)) dut (
        .clk_i         (clk),
        .reset_i       (r_reset),
        .cmd_valid_i   (r_valid),
        .cmd_ready_o   (w_ready),
        .cmd_up_i      (r_up),
        .cmd_stride2_i (r_s2),
        .cmd_steps_i   (r_steps),
        .abort_i       (r_abort),
        .ctrl_o        (w_ctrl),
        .busy_o        (w_busy),
        .done_o        (w_done),
        .aborted_o     (w_aborted),
        .steps_left_o  (w_steps_left)
    );

    always #5 clk = ~clk;

    // Downstream counter: hold, or step by 1 / 2 up or down, wrapping mod 8
    always @(posedge clk) begin
        if (r_reset)
            r_cnt <= 3'd0;
        else if (!w_ctrl[3])
            r_cnt <= w_ctrl[0] ? r_cnt + ((w_ctrl[1] | w_ctrl[2]) ? 3'd2 : 3'd1)
                               : r_cnt - ((w_ctrl[1] | w_ctrl[2]) ? 3'd2 : 3'd1);
    end

    always @(negedge clk) begin
        if (w_done === 1'b1 && w_aborted === 1'b1) begin
            errors++;
            $display("FAIL done_and_aborted: both high at %0t", $time);
        end
    end

    typedef struct {
        logic       v, up, s2;
        logic [7:0] st;
        logic       ab, rs;
        logic       rdy;
        logic [3:0] ctrl;
        logic       busy, done, abt;
        logic [7:0] sl;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic up, logic s2, logic [7:0] st, logic ab,
                                logic rs, logic rdy, logic [3:0] ctrl, logic busy,
                                logic done, logic abt, logic [7:0] sl, logic [2:0] cnt);
        vec_t e;
        e.v = v; e.up = up; e.s2 = s2; e.st = st; e.ab = ab; e.rs = rs;
        e.rdy = rdy; e.ctrl = ctrl; e.busy = busy; e.done = done; e.abt = abt;
        e.sl = sl; e.cnt = cnt;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic up, input logic s2, input logic [7:0] st);
        r_valid = v; r_up = up; r_s2 = s2; r_steps = st;
    endtask

    int done_cnt;
    int step_cnt;
    logic [3:0] exp_t4 [7];

    initial begin
        r_reset = 1'b1; r_abort = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        tick();

        //   v  up s2 st    ab rs | rdy ctrl    busy done abt sl   cnt
        // reset held, then release: idle and stable
        add(0, 0, 0, 8'd0, 0, 1,   1, 4'b1000, 0, 0, 0, 8'd0, 3'd0);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 0, 0, 0, 8'd0, 3'd0);
        // up by 1, five steps
        add(1, 1, 0, 8'd5, 0, 0,   1, 4'b0001, 1, 0, 0, 8'd5, 3'd0);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0001, 1, 0, 0, 8'd4, 3'd1);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0001, 1, 0, 0, 8'd3, 3'd2);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0001, 1, 0, 0, 8'd2, 3'd3);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0001, 1, 0, 0, 8'd1, 3'd4);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 1, 1, 0, 8'd0, 3'd5);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 0, 0, 0, 8'd0, 3'd5);
        // zero-step command
        add(1, 1, 0, 8'd0, 0, 0,   1, 4'b1000, 1, 1, 0, 8'd0, 3'd5);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 0, 0, 0, 8'd0, 3'd5);
        // down by 1, four steps: 5 -> 1
        add(1, 0, 0, 8'd4, 0, 0,   1, 4'b0000, 1, 0, 0, 8'd4, 3'd5);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0000, 1, 0, 0, 8'd3, 3'd4);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0000, 1, 0, 0, 8'd2, 3'd3);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0000, 1, 0, 0, 8'd1, 3'd2);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 1, 1, 0, 8'd0, 3'd1);
        // accepted in FIN: down by 2, three steps: 1 -> 7 -> 5 -> 3
        add(1, 0, 1, 8'd3, 0, 0,   1, 4'b0110, 1, 0, 0, 8'd3, 3'd1);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0110, 1, 0, 0, 8'd2, 3'd7);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b0110, 1, 0, 0, 8'd1, 3'd5);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 1, 1, 0, 8'd0, 3'd3);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 0, 0, 0, 8'd0, 3'd3);
        // abort while idle: pulses, and the concurrent command is refused
        add(1, 1, 0, 8'd5, 1, 0,   0, 4'b1000, 0, 0, 1, 8'd0, 3'd3);
        add(0, 0, 0, 8'd0, 0, 0,   1, 4'b1000, 0, 0, 0, 8'd0, 3'd3);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].up, tbl[i].s2, tbl[i].st);
            r_abort = tbl[i].ab;
            r_reset = tbl[i].rs;
            #1;
            chk($sformatf("v%0d ready", i), 32'(w_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("v%0d ctrl", i), 32'(w_ctrl), 32'(tbl[i].ctrl));
            chk($sformatf("v%0d busy", i), 32'(w_busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d done", i), 32'(w_done), 32'(tbl[i].done));
            chk($sformatf("v%0d aborted", i), 32'(w_aborted), 32'(tbl[i].abt));
            chk($sformatf("v%0d steps_left", i), 32'(w_steps_left), 32'(tbl[i].sl));
            chk($sformatf("v%0d cnt", i), 32'(r_cnt), 32'(tbl[i].cnt));
        end
        r_reset = 1'b0; r_abort = 1'b0;

        // Pending command queued during RUN, started after one FIN cycle
        drive(1'b1, 1'b1, 1'b0, 8'd4);
        tick();
        chk("t4 first ctrl", 32'(w_ctrl), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 8'd2);
        #1;
        chk("t4 ready before 2nd", 32'(w_ready), 32'h1);
        tick();
        chk("t4 ready after 2nd", 32'(w_ready), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        exp_t4 = '{4'h1, 4'h1, 4'h8, 4'h1, 4'h1, 4'h8, 4'h8};
        done_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("t4 ctrl e%0d", k + 2), 32'(w_ctrl), 32'(exp_t4[k]));
            if (w_done === 1'b1) done_cnt++;
            if (k == 3) chk("t4 ready after pend start", 32'(w_ready), 32'h1);
        end
        chk("t4 done pulses", 32'(done_cnt), 32'd2);
        chk("t4 busy end", 32'(w_busy), 32'h0);
        chk("t4 cnt", 32'(r_cnt), 32'd1);

        // Abort in the third of six STEP cycles with a command pending
        drive(1'b1, 1'b1, 1'b0, 8'd6);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'd2);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        r_abort = 1'b1;
        #1;
        chk("t6 ready during abort", 32'(w_ready), 32'h0);
        tick();
        r_abort = 1'b0;
        chk("t6 ctrl", 32'(w_ctrl), 32'h8);
        chk("t6 aborted", 32'(w_aborted), 32'h1);
        chk("t6 done", 32'(w_done), 32'h0);
        chk("t6 busy", 32'(w_busy), 32'h0);
        chk("t6 steps_left", 32'(w_steps_left), 32'h0);
        chk("t6 cnt", 32'(r_cnt), 32'd4);
        done_cnt = 0;
        step_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) chk("t6 aborted drops", 32'(w_aborted), 32'h0);
            if (w_done === 1'b1) done_cnt++;
            if (w_ctrl !== 4'h8) step_cnt++;
        end
        chk("t6 no done", 32'(done_cnt), 32'd0);
        chk("t6 pending dropped", 32'(step_cnt), 32'd0);
        chk("t6 cnt stable", 32'(r_cnt), 32'd4);

        // Reset in the middle of RUN
        drive(1'b1, 1'b1, 1'b0, 8'd5);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        chk("rst cnt before", 32'(r_cnt), 32'd6);
        r_reset = 1'b1;
        tick();
        r_reset = 1'b0;
        chk("rst ctrl", 32'(w_ctrl), 32'h8);
        chk("rst aborted", 32'(w_aborted), 32'h0);
        chk("rst done", 32'(w_done), 32'h0);
        chk("rst busy", 32'(w_busy), 32'h0);
        chk("rst steps_left", 32'(w_steps_left), 32'h0);
        tick();
        chk("rst ctrl stays", 32'(w_ctrl), 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
